// File: rtl/prio_enc_serializer.sv
// prio_enc_serializer
//   Captures an N-bit request vector and emits the index of every set bit in
//   priority order, one index per accepted valid/ready handshake. Each bit is
//   cleared once its index has been accepted.
//
// Parameters
//   N          number of request lines (2..256); index width W = $clog2(N)
//   PRIO_HIGH  1: highest set index wins; 0: lowest set index wins
//   ACCUM      1: req_i is ORed into pending while scanning; 0: sampled on load only
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req_i    request vector
//   load_i   capture req_i (honoured only when idle with ei high)
//   ei       enable; low pauses scanning and blocks load
//   idx_o    index of the current winning pending bit
//   valid_o  idx_o is valid
//   ready_i  consumer accepts idx_o when valid_o & ready_i
//   gs_o     pending is non-zero
//   busy_o   FSM is scanning
//   done_o   one-cycle pulse when the batch completes
//   eo_o     one-cycle pulse when a load captured an all-zero vector
module prio_enc_serializer #(
  parameter int unsigned N         = 16,
  parameter bit          PRIO_HIGH = 1'b1,
  parameter bit          ACCUM     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic                 load_i,
  input  logic                 ei,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 gs_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 eo_o
);

  localparam int unsigned W = $clog2(N);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   clr_mask;
  logic [W-1:0]   idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           gs_q, gs_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           eo_q, eo_d;
  logic           hs;

  // Priority encode; returns prev when vec is empty so the index never goes X.
  function automatic logic [W-1:0] prio_enc(input logic [N-1:0] vec, input logic [W-1:0] prev);
    logic [W-1:0] r;
    r = prev;
    if (PRIO_HIGH) begin
      for (int i = 0; i < int'(N); i++) begin
        if (vec[i]) r = W'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (vec[i]) r = W'(i);
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    clr_mask  = '0;
    done_d    = 1'b0;
    eo_d      = 1'b0;
    hs        = valid_q & ready_i;

    unique case (state_q)
      StIdle: begin
        if (load_i && ei) begin
          if (|req_i) begin
            pending_d = req_i;
            state_d   = StScan;
          end else begin
            eo_d   = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      StScan: begin
        if (hs) clr_mask[idx_q] = 1'b1;
        pending_d = pending_q & ~clr_mask;
        // A merged request equal to the acked bit re-arms it as a new event.
        if (ACCUM && ei) pending_d = pending_d | req_i;
        if (pending_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    idx_d   = prio_enc(pending_d, idx_q);
    gs_d    = |pending_d;
    busy_d  = (state_d == StScan);
    valid_d = ei & gs_d & busy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      gs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eo_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      gs_q      <= gs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      eo_q      <= eo_d;
    end
  end

  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign gs_o    = gs_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign eo_o    = eo_q;

endmodule

// File: tb/tb_prio_enc_serializer.sv
// Directed bench for prio_enc_serializer. Three instances share clock, reset,
// load, ei and ready: a (N=16, high priority), b (N=16, accumulate),
// c (N=12, low priority). Expected indices are queued when a batch is loaded
// and popped whenever the selected instance completes a handshake.
module tb_prio_enc_serializer;

  logic        clk = 1'b0;
  logic        rst, load, ei, ready;
  logic [15:0] req_a, req_b;
  logic [11:0] req_c;
  logic [3:0]  idx_a, idx_b, idx_c;
  logic        valid_a, gs_a, busy_a, done_a, eo_a;
  logic        valid_b, gs_b, busy_b, done_b, eo_b;
  logic        valid_c, gs_c, busy_c, done_c, eo_c;

  int          vectors = 0;
  int          miscompares = 0;
  int          hs_cnt = 0;
  int          sel = 0;
  logic [3:0]  sb[$];

  always #5 clk = ~clk;

  prio_enc_serializer #(.N(16), .PRIO_HIGH(1'b1), .ACCUM(1'b0)) u_a (
    .clk(clk), .rst(rst), .req_i(req_a), .load_i(load), .ei(ei), .idx_o(idx_a),
    .valid_o(valid_a), .ready_i(ready), .gs_o(gs_a), .busy_o(busy_a), .done_o(done_a),
    .eo_o(eo_a)
  );

  prio_enc_serializer #(.N(16), .PRIO_HIGH(1'b1), .ACCUM(1'b1)) u_b (
    .clk(clk), .rst(rst), .req_i(req_b), .load_i(load), .ei(ei), .idx_o(idx_b),
    .valid_o(valid_b), .ready_i(ready), .gs_o(gs_b), .busy_o(busy_b), .done_o(done_b),
    .eo_o(eo_b)
  );

  prio_enc_serializer #(.N(12), .PRIO_HIGH(1'b0), .ACCUM(1'b0)) u_c (
    .clk(clk), .rst(rst), .req_i(req_c), .load_i(load), .ei(ei), .idx_o(idx_c),
    .valid_o(valid_c), .ready_i(ready), .gs_o(gs_c), .busy_o(busy_c), .done_o(done_c),
    .eo_o(eo_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hs_obs(input logic [3:0] idx);
    logic [3:0] e;
    hs_cnt++;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_underflow: observed handshake idx %0d expected none", idx);
    end else begin
      e = sb.pop_front();
      chk("hs_idx", {28'd0, idx}, {28'd0, e});
    end
  endtask

  // Inputs are changed just before calling; outputs are sampled on the negedge after.
  task automatic step();
    if (sel == 0 && valid_a && ready) hs_obs(idx_a);
    else if (sel == 1 && valid_b && ready) hs_obs(idx_b);
    else if (sel == 2 && valid_c && ready) hs_obs(idx_c);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int h0;
    logic [3:0] exp3 [7];
    rst = 1'b1; load = 1'b0; ei = 1'b1; ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_idx", {28'd0, idx_a}, 0);
    chk("rst_valid", {31'd0, valid_a}, 0);
    chk("rst_gs", {31'd0, gs_a}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_eo", {31'd0, eo_a}, 0);

    // 8421 with ready held high: one index per clock.
    sel = 0;
    req_a = 16'h8421; ready = 1'b1; load = 1'b1;
    sb.push_back(4'd15); sb.push_back(4'd10); sb.push_back(4'd5); sb.push_back(4'd0);
    step();
    load = 1'b0; req_a = '0;
    chk("t1_busy", {31'd0, busy_a}, 1);
    chk("t1_gs", {31'd0, gs_a}, 1);
    chk("t1_valid", {31'd0, valid_a}, 1);
    chk("t1_idx0", {28'd0, idx_a}, 15);
    step();
    chk("t1_idx1", {28'd0, idx_a}, 10);
    step();
    chk("t1_idx2", {28'd0, idx_a}, 5);
    step();
    chk("t1_idx3", {28'd0, idx_a}, 0);
    chk("t1_done_early", {31'd0, done_a}, 0);
    step();
    chk("t1_done", {31'd0, done_a}, 1);
    chk("t1_valid_end", {31'd0, valid_a}, 0);
    chk("t1_busy_end", {31'd0, busy_a}, 0);
    chk("t1_gs_end", {31'd0, gs_a}, 0);
    chk("t1_sb", sb.size(), 0);
    step();
    chk("t1_done_pulse", {31'd0, done_a}, 0);

    // All-zero load.
    req_a = '0; load = 1'b1;
    step();
    load = 1'b0;
    chk("t2_eo", {31'd0, eo_a}, 1);
    chk("t2_done", {31'd0, done_a}, 1);
    chk("t2_valid", {31'd0, valid_a}, 0);
    chk("t2_busy", {31'd0, busy_a}, 0);
    step();
    chk("t2_eo_pulse", {31'd0, eo_a}, 0);
    chk("t2_done_pulse", {31'd0, done_a}, 0);
    chk("t2_busy_after", {31'd0, busy_a}, 0);

    // 00F0 with ready toggling: indices hold while ready is low.
    req_a = 16'h00F0; ready = 1'b1; load = 1'b1;
    sb.push_back(4'd7); sb.push_back(4'd6); sb.push_back(4'd5); sb.push_back(4'd4);
    step();
    load = 1'b0; req_a = '0;
    h0 = hs_cnt;
    exp3[0] = 4'd7; exp3[1] = 4'd6; exp3[2] = 4'd6; exp3[3] = 4'd5;
    exp3[4] = 4'd5; exp3[5] = 4'd4; exp3[6] = 4'd4;
    for (int c = 0; c < 7; c++) begin
      ready = (c % 2 == 0);
      chk("t3_idx", {28'd0, idx_a}, {28'd0, exp3[c]});
      chk("t3_valid", {31'd0, valid_a}, 1);
      step();
    end
    chk("t3_done", {31'd0, done_a}, 1);
    chk("t3_hs_count", hs_cnt - h0, 4);
    chk("t3_sb", sb.size(), 0);

    // 0101 with an ei pause after the first handshake.
    ready = 1'b1; req_a = 16'h0101; load = 1'b1;
    sb.push_back(4'd8); sb.push_back(4'd0);
    step();
    load = 1'b0; req_a = '0;
    chk("t4_idx8", {28'd0, idx_a}, 8);
    step();
    chk("t4_idx0_pre", {28'd0, idx_a}, 0);
    ready = 1'b0; ei = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_pause_valid", {31'd0, valid_a}, 0);
      chk("t4_pause_gs", {31'd0, gs_a}, 1);
      chk("t4_pause_busy", {31'd0, busy_a}, 1);
    end
    ei = 1'b1;
    step();
    chk("t4_resume_valid", {31'd0, valid_a}, 1);
    chk("t4_resume_idx", {28'd0, idx_a}, 0);
    ready = 1'b1;
    step();
    chk("t4_done", {31'd0, done_a}, 1);
    chk("t4_sb", sb.size(), 0);

    // Accumulate: re-arm bit 1 and add bit 15 while acking bit 1.
    sel = 1;
    req_b = 16'h0002; load = 1'b1;
    sb.push_back(4'd1); sb.push_back(4'd15); sb.push_back(4'd1);
    step();
    load = 1'b0; req_b = '0;
    chk("t5_idx1", {28'd0, idx_b}, 1);
    req_b = 16'h8002;
    step();
    req_b = '0;
    chk("t5_idx15", {28'd0, idx_b}, 15);
    chk("t5_valid", {31'd0, valid_b}, 1);
    step();
    chk("t5_idx1_again", {28'd0, idx_b}, 1);
    chk("t5_no_done", {31'd0, done_b}, 0);
    step();
    chk("t5_done", {31'd0, done_b}, 1);
    chk("t5_sb", sb.size(), 0);

    // Low priority, N=12, reset mid-batch.
    sel = 2;
    req_c = 12'hA05; load = 1'b1;
    sb.push_back(4'd0); sb.push_back(4'd2);
    step();
    load = 1'b0; req_c = '0;
    chk("t6_idx0", {28'd0, idx_c}, 0);
    step();
    chk("t6_idx2", {28'd0, idx_c}, 2);
    step();
    chk("t6_idx9", {28'd0, idx_c}, 9);
    chk("t6_sb", sb.size(), 0);
    ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_idx", {28'd0, idx_c}, 0);
    chk("t6_rst_valid", {31'd0, valid_c}, 0);
    chk("t6_rst_gs", {31'd0, gs_c}, 0);
    chk("t6_rst_busy", {31'd0, busy_c}, 0);
    chk("t6_rst_done", {31'd0, done_c}, 0);
    chk("t6_rst_eo", {31'd0, eo_c}, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t6_no_done", {31'd0, done_c}, 0);
      chk("t6_stay_idle", {31'd0, busy_c}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
